// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: holds the PC, issues instruction fetches,
// applies branch redirects and stalls, and halts on request or on fetch timeout.
module pc_fetch_unit #(
   parameter int unsigned          WIDTH    = 32,
   parameter logic [WIDTH-1:0]     RESET_PC = '0,
   parameter int unsigned          STEP     = 4,
   parameter int unsigned          TIMEOUT  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic             i_halt,
   input  logic             i_resume,
   input  logic             i_br_taken,
   input  logic [WIDTH-1:0] i_br_target,
   input  logic             i_imem_ready,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_npc,
   output logic             o_fetch_req,
   output logic             o_halted,
   output logic [7:0]       o_wait_cnt,
   output logic             o_misaligned,
   output logic             o_timeout,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [7:0]       r_wait_cnt;
   logic             r_misaligned;
   logic             r_timeout;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_npc;
   logic [7:0]       w_wait_nxt;
   logic             w_mis_set;
   logic             w_to_set;

   assign w_npc = r_pc + STEP_W;

   // State register: reset wins over every other input in its cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_PC;
         r_wait_cnt   <= '0;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_wait_cnt   <= w_wait_nxt;
         r_misaligned <= r_misaligned | w_mis_set;
         r_timeout    <= r_timeout | w_to_set;
      end
   end

   // Handshake: o_fetch_req is held high for o_pc until a cycle with
   // i_imem_ready=1 completes it; a taken branch or halt drops the pending fetch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_wait_nxt  = r_wait_cnt;
      w_mis_set   = 1'b0;
      w_to_set    = 1'b0;
      case (r_state)
         ST_RUN, ST_WAIT: begin
            if (i_halt) begin
               w_state_nxt = ST_HALT;
               w_wait_nxt  = '0;
            end else if (i_br_taken) begin
               w_pc_nxt    = {i_br_target[WIDTH-1:2], 2'b00};
               w_mis_set   = |i_br_target[1:0];
               w_state_nxt = ST_RUN;
               w_wait_nxt  = '0;
            end else if (i_stall) begin
               w_state_nxt = r_state;
            end else if (i_imem_ready) begin
               w_pc_nxt    = w_npc;
               w_state_nxt = ST_RUN;
               w_wait_nxt  = '0;
            end else if (r_wait_cnt == TO_LAST) begin
               w_state_nxt = ST_HALT;
               w_to_set    = 1'b1;
               w_wait_nxt  = '0;
            end else begin
               w_state_nxt = ST_WAIT;
               w_wait_nxt  = r_wait_cnt + 8'd1;
            end
         end
         ST_HALT: begin
            if (i_resume && !i_halt) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_comb begin
      o_pc         = r_pc;
      o_npc        = w_npc;
      o_fetch_req  = (r_state != ST_HALT) && !i_rst;
      o_halted     = (r_state == ST_HALT);
      o_wait_cnt   = r_wait_cnt;
      o_misaligned = r_misaligned;
      o_timeout    = r_timeout;
      o_dbg_state  = r_state;
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with TIMEOUT=4: reset, sequential fetch,
// branch priority, misalignment, timeout, halt/resume, wrap-around and mid-WAIT reset.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, stall, halt, resume, br_taken, imem_ready;
   logic [31:0] br_target;
   logic [31:0] pc, npc;
   logic        fetch_req, halted, misaligned, timeout;
   logic [7:0]  wait_cnt;
   logic [1:0]  dbg_state;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .WIDTH(32), .RESET_PC(32'h0), .STEP(4), .TIMEOUT(4)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt),
      .i_resume(resume), .i_br_taken(br_taken), .i_br_target(br_target),
      .i_imem_ready(imem_ready), .o_pc(pc), .o_npc(npc),
      .o_fetch_req(fetch_req), .o_halted(halted), .o_wait_cnt(wait_cnt),
      .o_misaligned(misaligned), .o_timeout(timeout), .o_dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
      br_taken = 1'b0; br_target = 32'h0; imem_ready = 1'b0;
      step(); step();
      check("rst_pc", pc, 32'h0);
      check("rst_npc", npc, 32'h4);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_wait", {24'b0, wait_cnt}, 32'h0);
      check("rst_mis", {31'b0, misaligned}, 32'h0);
      check("rst_to", {31'b0, timeout}, 32'h0);
      check("rst_freq_in_rst", {31'b0, fetch_req}, 32'h0);

      // free run
      rst = 1'b0; imem_ready = 1'b1; #1;
      check("run_freq0", {31'b0, fetch_req}, 32'h1);
      step();
      check("run_pc4", pc, 32'h4);
      check("run_npc8", npc, 32'h8);
      step();
      check("run_pc8", pc, 32'h8);
      check("run_freq8", {31'b0, fetch_req}, 32'h1);

      // branch beats stall and ready
      br_taken = 1'b1; br_target = 32'h40; stall = 1'b1;
      step();
      check("br_prio_pc", pc, 32'h40);
      check("br_prio_mis", {31'b0, misaligned}, 32'h0);

      // misaligned branch
      stall = 1'b0; br_target = 32'h43;
      step();
      check("mis_pc", pc, 32'h40);
      check("mis_flag", {31'b0, misaligned}, 32'h1);
      br_taken = 1'b0;
      step(); step(); step();
      check("mis_adv_pc", pc, 32'h4c);
      check("mis_sticky", {31'b0, misaligned}, 32'h1);

      // wait and timeout from 0x10
      br_taken = 1'b1; br_target = 32'h10;
      step();
      br_taken = 1'b0; imem_ready = 1'b0;
      check("to_pc_start", pc, 32'h10);
      step();
      check("to_wait1", {24'b0, wait_cnt}, 32'h1);
      step();
      check("to_wait2", {24'b0, wait_cnt}, 32'h2);
      check("to_freq_wait", {31'b0, fetch_req}, 32'h1);
      step();
      check("to_wait3", {24'b0, wait_cnt}, 32'h3);
      check("to_not_yet", {31'b0, timeout}, 32'h0);
      step();
      check("to_halted", {31'b0, halted}, 32'h1);
      check("to_flag", {31'b0, timeout}, 32'h1);
      check("to_freq", {31'b0, fetch_req}, 32'h0);
      check("to_pc", pc, 32'h10);
      check("to_wait0", {24'b0, wait_cnt}, 32'h0);
      resume = 1'b1;
      step();
      resume = 1'b0;
      check("res_halted", {31'b0, halted}, 32'h0);
      check("res_freq", {31'b0, fetch_req}, 32'h1);
      check("res_pc", pc, 32'h10);
      check("res_to_sticky", {31'b0, timeout}, 32'h1);

      // halt handling at 0x20
      br_taken = 1'b1; br_target = 32'h20;
      step();
      br_taken = 1'b0;
      check("h_pc20", pc, 32'h20);
      halt = 1'b1;
      step();
      check("h_halted", {31'b0, halted}, 32'h1);
      halt = 1'b0; br_taken = 1'b1; br_target = 32'h80; imem_ready = 1'b1;
      step();
      br_taken = 1'b0; imem_ready = 1'b0;
      check("h_br_ignored", pc, 32'h20);
      check("h_still", {31'b0, halted}, 32'h1);
      halt = 1'b1; resume = 1'b1;
      step();
      check("h_both", {31'b0, halted}, 32'h1);
      halt = 1'b0;
      step();
      resume = 1'b0;
      check("h_resumed", {31'b0, halted}, 32'h0);
      check("h_res_pc", pc, 32'h20);

      // wrap-around
      br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
      step();
      br_taken = 1'b0; imem_ready = 1'b1;
      check("wr_pc", pc, 32'hFFFF_FFFC);
      check("wr_npc", npc, 32'h0);
      step();
      check("wr_pc0", pc, 32'h0);

      // reset mid-WAIT
      imem_ready = 1'b0;
      step(); step();
      check("mw_wait2", {24'b0, wait_cnt}, 32'h2);
      check("mw_mis_before", {31'b0, misaligned}, 32'h1);
      rst = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 32'h100;
      step();
      check("mw_pc", pc, 32'h0);
      check("mw_wait", {24'b0, wait_cnt}, 32'h0);
      check("mw_halted", {31'b0, halted}, 32'h0);
      check("mw_mis", {31'b0, misaligned}, 32'h0);
      check("mw_to", {31'b0, timeout}, 32'h0);
      rst = 1'b0; stall = 1'b0; br_taken = 1'b0; #1;
      check("mw_freq", {31'b0, fetch_req}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and fetch sequencer for the KGP-miniRISC datapath.
- Built from the same clocked flip-flop style as the register primitives.
- Holds the current PC and drives fetch requests to instruction memory.
- Applies branch redirects from the execute stage, stalls, halts on request or on fetch timeout, and feeds the fetched PC into decode.

Parameters:
WIDTH, 32, PC and address width in bits
RESET_PC, 0, PC value loaded on reset
STEP, 4, byte increment per sequential instruction
TIMEOUT, 16, consecutive not-ready fetch cycles before forced halt (1..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC this cycle (hazard from downstream)
halt  in  1  request entry into HALT
resume  in  1  request exit from HALT
br_taken  in  1  redirect PC this cycle
br_target  in  WIDTH  redirect target byte address
imem_ready  in  1  instruction memory accepted/returned current fetch
pc  out  WIDTH  current PC (registered)
npc  out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH
fetch_req  out  1  fetch of pc requested this cycle
halted  out  1  state == HALT
wait_cnt  out  8  consecutive not-ready cycles in current fetch
misaligned  out  1  sticky: a taken branch had br_target[1:0] != 0
timeout  out  1  sticky: fetch timed out

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: synchronous and active-high.
- Reset, evaluated at a clk edge with rst=1: pc=RESET_PC, state=RUN, wait_cnt=0, misaligned=0, timeout=0.
- Outputs after the reset edge: halted=0, npc=RESET_PC+STEP.
- fetch_req = (state==RUN or WAIT) and !rst. It is therefore 1 in the first cycle after rst deasserts.
- States: RUN (fetch issued, first cycle), WAIT (fetch pending, memory not ready), HALT (idle).
- RUN/WAIT per-edge priority, highest first:
  1. halt=1: go to HALT; pc held; wait_cnt=0.
  2. br_taken=1: pc <= {br_target[WIDTH-1:2],2'b00}; misaligned set if br_target[1:0]!=0; state RUN; wait_cnt=0. This applies even if imem_ready=1; the pending fetch is discarded.
  3. stall=1: pc, state and wait_cnt all held.
  4. imem_ready=1: pc <= pc+STEP (wraps to 0 past 2^WIDTH-1); state RUN; wait_cnt=0.
  5. Otherwise: state WAIT; pc held; wait_cnt <= wait_cnt+1.
     - If wait_cnt == TIMEOUT-1 at this edge: go to HALT instead, set timeout, wait_cnt=0.
- HALT:
  - pc held; fetch_req=0; halted=1.
  - br_taken, stall and imem_ready are ignored.
  - resume=1 with halt=0: state RUN next edge, pc unchanged; fetch of the same pc is re-issued.
  - halt=1 and resume=1 together: stay in HALT.
- Sticky flags (misaligned, timeout) clear only on rst; resume does not clear them.
- Reset mid-operation (WAIT or HALT, any inputs): the next edge gives the full reset state. All other inputs are ignored in that cycle.
- Latency:
  - A redirect is visible on pc one cycle after the br_taken edge.
  - The sequential advance is visible one cycle after the imem_ready edge.
- No combinational path from inputs to pc. npc depends on pc only.

Test Plan:
- Reset then free-run: rst=1 for 2 cycles, then rst=0 with imem_ready=1 -> pc 0,4,8,12 on consecutive edges; fetch_req=1 throughout; npc = pc+4.
- Branch versus stall and ready: at pc=8, assert br_taken=1, br_target=0x40, stall=1, imem_ready=1 in the same cycle -> next pc=0x40, misaligned=0.
- Misaligned branch: br_target=0x43 -> next pc=0x40 and misaligned=1. After 3 further cycles misaligned is still 1, and it clears only after rst.
- Wait and timeout: TIMEOUT=4, imem_ready=0 from pc=0x10.
  - wait_cnt goes 1,2,3, then state HALT with timeout=1, halted=1, fetch_req=0, pc=0x10.
  - Then resume=1 -> RUN, fetch_req=1, pc=0x10, timeout still 1.
- Halt handling: in RUN at pc=0x20, halt=1.
  - Next edge halted=1. br_taken=1 with br_target=0x80 while halted -> pc stays 0x20.
  - halt=1 with resume=1 -> stays halted; resume=1 alone -> RUN.
- Wrap-around and reset mid-WAIT:
  - Branch to 0xFFFFFFFC, then imem_ready=1 -> pc=0x00000000.
  - Then imem_ready=0 for 2 cycles, then rst=1 for one edge -> pc=RESET_PC, wait_cnt=0, halted=0.
